// File: rtl/balanca_pkg.sv
// rtl/balanca_pkg.sv - shared widths, constants and state encoding for the price calculator
package balanca_pkg;

  localparam int PESO_W    = 12;
  localparam int PRECO_W   = 10;
  localparam int CENT_W    = 10;
  localparam int MAX_CENT  = 999;
  localparam int PROD_W    = PESO_W + PRECO_W;
  localparam int DIVISOR   = 1000;
  localparam int ROUND_ADD = 500;
  localparam int CNT_W     = $clog2(PESO_W) + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_ROUND = 3'd2,
    ST_DIV   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/balanca_div_const.sv
// rtl/balanca_div_const.sv - serial restoring divider by a constant, one quotient bit per cycle
module balanca_div_const #(
  parameter int W       = 22,
  parameter int DIVISOR = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int RW = $clog2(DIVISOR) + 1;
  localparam int CW = $clog2(W);

  logic [RW-1:0] rem;
  logic [RW-1:0] rem_sh;
  logic [RW-1:0] dvs;
  logic          ge;
  logic          run;
  logic [CW-1:0] cnt;

  // trial step: shift next dividend bit into the partial remainder and compare
  always_comb begin
    dvs    = RW'(DIVISOR);
    rem_sh = {rem[RW-2:0], quotient[W-1]};
    ge     = (rem_sh >= dvs);
  end

  // done marks the final step; the quotient register is complete after this edge
  assign done = run && (cnt == CW'(W - 1));

  // quotient shares the dividend shift register; bits enter at the LSB as they resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      quotient <= '0;
      cnt      <= '0;
      run      <= 1'b0;
    end else if (start) begin
      rem      <= '0;
      quotient <= dividend;
      cnt      <= '0;
      run      <= 1'b1;
    end else if (run) begin
      rem      <= ge ? (rem_sh - dvs) : rem_sh;
      quotient <= {quotient[W-2:0], ge};
      cnt      <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/balanca_preco_calc.sv
// rtl/balanca_preco_calc.sv - weight x price to rounded, saturated centimos (optional tare: BALANCA_TARA_EN)
module balanca_preco_calc
  import balanca_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PESO_W-1:0] peso_g,
`ifdef BALANCA_TARA_EN
  input  logic [PESO_W-1:0] tara_g,
`endif
  input  logic [PRECO_W-1:0] preco_kg,
  output logic [CENT_W-1:0] centimos,
  output logic              valid,
  output logic              busy,
  output logic              overflow
);

  state_t            state;
  logic [PESO_W-1:0] operand;
  logic [PESO_W-1:0] mplier;
  logic [PROD_W-1:0] mcand;
  logic [PROD_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              div_start;
  logic              div_done;
  logic [PROD_W-1:0] div_dividend;
  logic [PROD_W-1:0] div_q;

  // net weight feeding the multiplier; tare never drives it negative
  always_comb begin
`ifdef BALANCA_TARA_EN
    operand = (tara_g > peso_g) ? '0 : (peso_g - tara_g);
`else
    operand = peso_g;
`endif
  end

  // the ROUND cycle hands product+500 straight to the divider
  assign div_start    = (state == ST_ROUND);
  assign div_dividend = acc + PROD_W'(ROUND_ADD);

  balanca_div_const #(
    .W       (PROD_W),
    .DIVISOR (DIVISOR)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .done     (div_done),
    .quotient (div_q)
  );

  // control FSM: shift-add multiply, round, divide, then register the saturated result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      centimos <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mplier <= operand;
            mcand  <= PROD_W'(preco_kg);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_MUL;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(PESO_W - 1)) state <= ST_ROUND;
        end
        ST_ROUND: state <= ST_DIV;
        ST_DIV: if (div_done) state <= ST_DONE;
        ST_DONE: begin
          if (div_q > PROD_W'(MAX_CENT)) begin
            centimos <= CENT_W'(MAX_CENT);
            overflow <= 1'b1;
          end else begin
            centimos <= div_q[CENT_W-1:0];
            overflow <= 1'b0;
          end
          valid <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_balanca_preco_calc.sv
// tb/tb_balanca_preco_calc.sv - self-checking bench for balanca_preco_calc
module tb_balanca_preco_calc;

  localparam int LAT_N = 37;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] peso_g;
  logic [11:0] tara_g;
  logic [9:0]  preco_kg;
  logic [9:0]  centimos;
  logic        valid;
  logic        busy;
  logic        overflow;

  typedef struct {
    int peso;
    int preco;
    int tara;
    int cent;
    int ovf;
  } vec_t;

  typedef struct {
    int cent;
    int ovf;
    int s;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;

  always #5 clk = ~clk;

  balanca_preco_calc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .peso_g   (peso_g),
`ifdef BALANCA_TARA_EN
    .tara_g   (tara_g),
`endif
    .preco_kg (preco_kg),
    .centimos (centimos),
    .valid    (valid),
    .busy     (busy),
    .overflow (overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model(input int peso, input int preco, input int tara,
                                output int cent, output int ovf);
    longint eff;
    longint q;
`ifdef BALANCA_TARA_EN
    eff = (tara > peso) ? 0 : peso - tara;
`else
    eff = peso;
`endif
    q = (eff * preco + 500) / 1000;
    if (q > 999) begin cent = 999; ovf = 1; end
    else begin cent = int'(q); ovf = 0; end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst_n === 1'b1 && valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("centimos", int'(centimos), e.cent);
        chk("overflow", int'(overflow), e.ovf);
        chk("latency", ncyc - e.s, LAT_N);
      end
    end
  end

  // call just after a negedge; start is sampled by the following posedge
  task automatic start_op(input int peso, input int preco, input int tara,
                          input int cent, input int ovf);
    exp_t e;
    e.cent = cent; e.ovf = ovf; e.s = ncyc;
    peso_g = 12'(peso); preco_kg = 10'(preco); tara_g = 12'(tara);
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_neg();
    @(negedge clk); #1;
  endtask

  task automatic wait_valid(input int lim, output bit found, output bit gap);
    found = 1'b0; gap = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      wait_neg();
      if (busy !== 1'b1) gap = 1'b1;
      if (valid === 1'b1) found = 1'b1;
    end
  endtask

  initial begin
    bit found;
    bit gap;
    bit stray;
    int c;
    int o;
    vec_t v;

    vecs.push_back('{1700, 100, 0, 170, 0});
    vecs.push_back('{5,    100, 0, 1,   0});
    vecs.push_back('{4,    100, 0, 0,   0});
    vecs.push_back('{15,   100, 0, 2,   0});
    vecs.push_back('{4095, 999, 0, 999, 1});
    vecs.push_back('{1000, 250, 0, 250, 0});
    vecs.push_back('{0,    999, 0, 0,   0});
    vecs.push_back('{4095, 0,   0, 0,   0});
    vecs.push_back('{1000, 999, 0, 999, 0});
    vecs.push_back('{1001, 999, 0, 999, 1});
    vecs.push_back('{1499, 1,   0, 1,   0});
    vecs.push_back('{1500, 1,   0, 2,   0});
`ifdef BALANCA_TARA_EN
    vecs.push_back('{1800, 100, 100,  170, 0});
    vecs.push_back('{1800, 100, 2000, 0,   0});
`endif
    for (int i = 0; i < 4; i++) begin
      v.peso = int'($urandom_range(0, 4095));
      v.preco = int'($urandom_range(0, 999));
      v.tara = 0;
      model(v.peso, v.preco, v.tara, v.cent, v.ovf);
      vecs.push_back(v);
    end

    rst_n = 1'b0; start = 1'b0; peso_g = '0; preco_kg = '0; tara_g = '0;
    repeat (3) wait_neg();
    chk("rst_centimos", int'(centimos), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) wait_neg();

    foreach (vecs[i]) begin
      start_op(vecs[i].peso, vecs[i].preco, vecs[i].tara, vecs[i].cent, vecs[i].ovf);
      wait_valid(60, found, gap);
      chk("valid_seen", int'(found), 1);
      chk("busy_steady", int'(gap), 0);
      wait_neg();
      chk("valid_pulse", int'(valid), 0);
      chk("busy_drop", int'(busy), 0);
      chk("overflow_hold", int'(overflow), vecs[i].ovf);
      repeat (3) wait_neg();
      chk("centimos_hold", int'(centimos), vecs[i].cent);
    end

    // start re-pulsed mid-run with other operands must be ignored
    start_op(1700, 100, 0, 170, 0);
    repeat (9) wait_neg();
    peso_g = 12'd4095; preco_kg = 10'd999; start = 1'b1;
    wait_neg();
    start = 1'b0;
    wait_valid(60, found, gap);
    chk("restart_valid", int'(found), 1);
    chk("restart_busy", int'(gap), 0);
    repeat (45) wait_neg();
    chk("restart_queue", sb.size(), 0);

    // back-to-back: second start issued in the valid cycle of the first
    wait_neg();
    start_op(5, 100, 0, 1, 0);
    wait_valid(60, found, gap);
    chk("b2b_first", int'(found), 1);
    start_op(1000, 250, 0, 250, 0);
    chk("b2b_busy_kept", int'(busy), 1);
    wait_valid(60, found, gap);
    chk("b2b_second", int'(found), 1);
    chk("b2b_busy", int'(gap), 0);

    // reset mid-run aborts without a valid
    wait_neg();
    start_op(1700, 100, 0, 170, 0);
    repeat (19) wait_neg();
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_centimos", int'(centimos), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_overflow", int'(overflow), 0);
    repeat (2) wait_neg();
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (45) begin
      wait_neg();
      if (valid !== 1'b0) stray = 1'b1;
    end
    chk("arst_no_valid", int'(stray), 0);
    start_op(15, 100, 0, 2, 0);
    wait_valid(60, found, gap);
    chk("arst_recover", int'(found), 1);
    model(15, 100, 0, c, o);
    wait_neg();
    chk("arst_recover_val", int'(centimos), c);

    repeat (3) wait_neg();
    chk("queue_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/balanca_preco_calc.md
Name: balanca_preco_calc

Overview:
- Upstream stage of centimospaeuros: takes net weight (grams) and unit price (cents/kg) and produces the item total in cents on the 10-bit centimos bus that centimospaeuros consumes.
- Sequential shift-add multiplier, then round-half-up and a restoring divide by 1000.
- Result saturates at MAX_CENT.

Parameters:
- PESO_W, 12: weight width in grams (0..4095).
- PRECO_W, 10: price width in cents per kg (0..999).
- CENT_W, 10: output width; matches the centimospaeuros input.
- MAX_CENT, 999: saturation ceiling for centimos.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- peso_g  in  PESO_W  gross weight in grams; latched on the accepted start.
- preco_kg  in  PRECO_W  price in cents/kg; latched on the accepted start.
- centimos  out  CENT_W  rounded, saturated total; drives centimospaeuros.centimos.
- valid  out  1  one-cycle pulse when centimos is updated.
- busy  out  1  high from start acceptance until the valid cycle, inclusive.
- overflow  out  1  high with valid when the result was clipped to MAX_CENT; holds until the next valid.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - centimos=0, valid=0, busy=0, overflow=0.
  - All internal registers cleared.
  - Reset mid-operation aborts the computation; no valid is produced.
- Product width PROD_W = PESO_W+PRECO_W = 22. Worst case 4095*999+500 = 4,091,405 < 2^22, so no internal overflow.
- States:
  - IDLE: start=1 latches operands, clears the accumulator, sets busy, goes to MUL. start=0 stays in IDLE.
  - MUL: PESO_W cycles, one multiplier bit per cycle (LSB first): add the shifted preco_kg when the bit is 1. Then go to ROUND.
  - ROUND: 1 cycle, product += 500. Then go to DIV.
  - DIV: PROD_W cycles of restoring division by the constant 1000. Quotient is PROD_W bits; remainder is discarded. Then go to DONE.
  - DONE: 1 cycle.
    - If quotient > MAX_CENT: centimos=MAX_CENT, overflow=1.
    - Otherwise: centimos=quotient[CENT_W-1:0], overflow=0.
    - valid=1 this cycle only; busy drops after this cycle; return to IDLE.
- Latency:
  - The start sampled at edge k gives valid high in the cycle following edge k+PESO_W+1+PROD_W+1 (k+36 with defaults).
  - Back-to-back: a new start is accepted on the first IDLE cycle after DONE, giving one result every 37 cycles.
- start while busy is ignored (not queued). Operand changes while busy have no effect.
- centimos holds its last value between valid pulses.
- Rounding is half-up: result = floor((peso_g*preco_kg+500)/1000).
- Zero operands are legal and produce 0 with full latency.

Optional Feature:
- Macro: BALANCA_TARA_EN.
- Defined:
  - Adds port tara_g in PESO_W, latched on start.
  - Multiplier operand = peso_g - tara_g, clamped to 0 when tara_g > peso_g. No extra cycle; the subtract happens in the IDLE accept cycle.
- Undefined: tara_g does not exist; operand = peso_g.

Decomposition:
- Shared package/include balanca_pkg: PESO_W, PRECO_W, CENT_W, MAX_CENT, the divisor constant 1000, the rounding constant 500, and the state encodings (IDLE/MUL/ROUND/DIV/DONE, 3-bit).
- One natural sub-module: balanca_div_const, a restoring serial divider (start, dividend, done, quotient). It is reusable by the display path.

Test Plan:
- peso_g=1700, preco_kg=100, start pulse -> after 36 cycles valid=1 for 1 cycle, centimos=170, overflow=0; centimospaeuros then shows 1 euro / 70 cents.
- Rounding:
  - peso_g=5, preco_kg=100 -> centimos=1.
  - peso_g=4, preco_kg=100 -> centimos=0.
  - peso_g=15, preco_kg=100 -> centimos=2.
- peso_g=4095, preco_kg=999 -> centimos=999, overflow=1. A following run with peso_g=1000, preco_kg=250 -> centimos=250, overflow=0.
- start re-pulsed at cycle 10 of a run with different operands -> ignored; the first result is unchanged; busy stays high continuously until valid.
- rst_n low at cycle 20 of a run -> all outputs 0 immediately, no valid; a new start after release gives the correct result.
- With BALANCA_TARA_EN:
  - peso_g=1800, tara_g=100, preco_kg=100 -> centimos=170.
  - tara_g=2000, peso_g=1800 -> centimos=0.
